// File: rtl/base_lat_fifo_pkg.sv
// Shared helpers for the fixed-latency result fifo: sizing functions used for
// port widths and pointer widths.
package base_lat_fifo_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Pointer width for a depth-entry array; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/base_lat_fifo_mem.sv
// Result storage: depth x width register array, one write port, asynchronous
// read at the read pointer so the head of the fifo falls through to the output.
module base_lat_fifo_mem #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [PW-1:0]    i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [PW-1:0]    i_ra,
  output logic [WIDTH-1:0] o_rd
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: the data array has no reset; occupancy in the parent decides what is
  // valid, so clearing storage would only cost reset fan-out for no benefit.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wa] <= i_wd;
  end

  assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/base_lat_fifo.sv
// Credit-gated receiver for a fixed-latency pipeline: grants issue while credits
// remain, absorbs delayed results, and presents them downstream with valid/ready.
module base_lat_fifo
  import base_lat_fifo_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_issue_v,
  output logic                        o_issue_r,
  input  logic                        i_pd_v,
  input  logic [WIDTH-1:0]            i_pd_d,
  output logic                        o_v,
  input  logic                        o_r,
  output logic [WIDTH-1:0]            o_d,
  output logic [clog2(DEPTH+1)-1:0]   o_cnt,
  output logic                        o_perror
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  generate
    if (LAT < 1 || DEPTH < LAT + 1) begin : g_bad_params
      $error("base_lat_fifo: need LAT >= 1 and DEPTH >= LAT+1");
    end
  endgenerate

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_occ;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_perror;

  logic          w_issue;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic          w_drop_err;
  logic          w_credit_err;
  logic          w_cnt_err;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_occ_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  // Handshake outputs depend only on registered state.
  assign o_issue_r = (r_cnt != DEPTH_C);
  assign o_v       = (r_occ != '0);
  assign o_cnt     = r_cnt;
  assign o_perror  = r_perror;

  assign w_issue      = i_issue_v & o_issue_r;
  assign w_pop        = o_v & o_r;
  assign w_full       = (r_occ == DEPTH_C);
  assign w_wr         = i_pd_v & (~w_full | w_pop);
  assign w_drop_err   = i_pd_v & w_full & ~w_pop;
  assign w_credit_err = i_pd_v & (r_occ == r_cnt);

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_cnt_err = 1'b0;
    if (w_issue && !w_pop) begin
      if (r_cnt == DEPTH_C) w_cnt_err = 1'b1;
      else                  w_cnt_nxt = r_cnt + CW'(1);
    end else if (w_pop && !w_issue) begin
      if (r_cnt == '0) w_cnt_err = 1'b1;
      else             w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  always_comb begin
    w_occ_nxt = r_occ;
    case ({w_wr, w_pop})
      2'b10:   w_occ_nxt = r_occ + CW'(1);
      2'b01:   w_occ_nxt = r_occ - CW'(1);
      default: w_occ_nxt = r_occ;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_occ    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_perror <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_occ <= w_occ_nxt;
      if (w_wr)  r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_drop_err || w_credit_err || w_cnt_err) r_perror <= 1'b1;
    end
  end

  base_lat_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk  (clk),
    .i_we (w_wr),
    .i_wa (r_wr_ptr),
    .i_wd (i_pd_d),
    .i_ra (r_rd_ptr),
    .o_rd (o_d)
  );

endmodule

// File: tb/tb_base_lat_fifo.sv
// Randomized bench for base_lat_fifo: a delay line feeds results back, and a
// queue-based model predicts credits, occupancy, output data and error flag.
module tb_base_lat_fifo;

  localparam int W     = 8;
  localparam int LAT   = 3;
  localparam int DEPTH = 5;
  localparam int CW    = 3;

  logic          clk;
  logic          reset;
  logic          i_issue_v;
  logic          o_issue_r;
  logic          i_pd_v;
  logic [W-1:0]  i_pd_d;
  logic          o_v;
  logic          o_r;
  logic [W-1:0]  o_d;
  logic [CW-1:0] o_cnt;
  logic          o_perror;

  logic [W-1:0]  iss_d;
  logic          inj_v;
  logic [W-1:0]  inj_d;
  logic          dl_v [LAT];
  logic [W-1:0]  dl_d [LAT];

  int n_vec;
  int n_err;

  base_lat_fifo #(.WIDTH(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_issue_v (i_issue_v),
    .o_issue_r (o_issue_r),
    .i_pd_v    (i_pd_v),
    .i_pd_d    (i_pd_d),
    .o_v       (o_v),
    .o_r       (o_r),
    .o_d       (o_d),
    .o_cnt     (o_cnt),
    .o_perror  (o_perror)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment delay line: launched ops emerge LAT cycles later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) begin
        dl_v[i] <= 1'b0;
        dl_d[i] <= '0;
      end
    end else begin
      dl_v[0] <= i_issue_v & o_issue_r;
      dl_d[0] <= iss_d;
      for (int i = 1; i < LAT; i++) begin
        dl_v[i] <= dl_v[i-1];
        dl_d[i] <= dl_d[i-1];
      end
    end
  end

  assign i_pd_v = dl_v[LAT-1] | inj_v;
  assign i_pd_d = inj_v ? inj_d : dl_d[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: issued = launched, not yet arrived; landed = in fifo.
  logic [W-1:0] issued_q [$];
  logic [W-1:0] landed_q [$];
  int           m_cnt;
  bit           m_perr;

  always @(negedge clk) begin : monitor
    int occ;
    bit pop;
    bit fire;
    if (!reset) begin
      issued_q.delete();
      landed_q.delete();
      m_cnt  = 0;
      m_perr = 1'b0;
    end else begin
      occ = landed_q.size();
      check("o_cnt", o_cnt, m_cnt);
      check("o_issue_r", o_issue_r, m_cnt != DEPTH);
      check("o_v", o_v, occ != 0);
      check("o_perror", o_perror, m_perr);
      if (o_v && o_r && occ != 0) check("o_d", o_d, landed_q[0]);

      pop  = (occ != 0) && o_r;
      fire = i_issue_v && (m_cnt != DEPTH);
      if (pop) void'(landed_q.pop_front());
      if (fire) issued_q.push_back(iss_d);

      if (i_pd_v) begin
        if (occ == m_cnt) m_perr = 1'b1;
        if (occ == DEPTH && !pop) m_perr = 1'b1;
        else if (inj_v) landed_q.push_back(inj_d);
        else if (issued_q.size() != 0) landed_q.push_back(issued_q.pop_front());
      end

      if (fire && !pop) m_cnt++;
      else if (pop && !fire) begin
        if (m_cnt == 0) m_perr = 1'b1;
        else m_cnt--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int fires;
    int stale;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    i_issue_v = 1'b0;
    o_r = 1'b0;
    iss_d = '0;
    inj_v = 1'b0;
    inj_d = '0;

    // Reset values.
    repeat (5) step();
    check("rst_o_v", o_v, 0);
    check("rst_o_cnt", o_cnt, 0);
    check("rst_o_issue_r", o_issue_r, 1);
    check("rst_o_perror", o_perror, 0);
    reset = 1'b1;

    // Streaming at full rate.
    o_r = 1'b1;
    for (int k = 0; k < 20; k++) begin
      i_issue_v = 1'b1;
      iss_d = W'(k);
      if (k == 10) begin
        check("stream_cnt", o_cnt, LAT + 1);
        check("stream_issue_r", o_issue_r, 1);
      end
      step();
    end
    i_issue_v = 1'b0;
    repeat (LAT + 4) step();
    check("stream_drain_cnt", o_cnt, 0);

    // Backpressure: credits run out at DEPTH.
    o_r = 1'b0;
    i_issue_v = 1'b1;
    fires = 0;
    for (int i = 0; i < DEPTH + LAT + 3; i++) begin
      iss_d = W'($urandom);
      if (o_issue_r) fires++;
      step();
    end
    check("bp_fires", fires, DEPTH);
    check("bp_issue_r", o_issue_r, 0);
    check("bp_cnt", o_cnt, DEPTH);
    check("bp_o_v", o_v, 1);
    o_r = 1'b1;
    step();
    o_r = 1'b0;
    check("bp_credit_back", o_issue_r, 1);
    i_issue_v = 1'b0;
    o_r = 1'b1;
    repeat (DEPTH + LAT + 4) step();
    check("bp_drain_cnt", o_cnt, 0);

    // Randomized traffic with varying issue/ready densities.
    for (int i = 0; i < 1500; i++) begin
      i_issue_v = ($urandom_range(0, 3) < ((i / 300) % 4) + 1);
      o_r = ($urandom_range(0, 3) >= (i / 500));
      iss_d = W'($urandom);
      step();
    end
    i_issue_v = 1'b0;
    o_r = 1'b1;
    repeat (DEPTH + LAT + 4) step();
    check("rand_drain_cnt", o_cnt, 0);

    // Single round trips walk the pointers around several times.
    for (int r = 0; r < 10; r++) begin
      i_issue_v = 1'b1;
      iss_d = W'($urandom);
      o_r = 1'b0;
      step();
      i_issue_v = 1'b0;
      o_r = 1'b1;
      repeat (LAT + 2) step();
    end
    check("wrap_cnt", o_cnt, 0);

    // Result with nothing in flight: flag sticks, write still lands.
    check("err_pre", o_perror, 0);
    inj_v = 1'b1;
    inj_d = 8'hA5;
    step();
    inj_v = 1'b0;
    check("err_set", o_perror, 1);
    check("err_write_kept", o_v, 1);
    repeat (5) step();
    check("err_sticky", o_perror, 1);
    pulse_reset();
    check("err_cleared", o_perror, 0);

    // Result into a full fifo: dropped, contents unchanged.
    o_r = 1'b0;
    i_issue_v = 1'b1;
    for (int i = 0; i < DEPTH + LAT + 3; i++) begin
      iss_d = W'($urandom);
      step();
    end
    i_issue_v = 1'b0;
    step();
    check("full_pre_perr", o_perror, 0);
    check("full_pre_cnt", o_cnt, DEPTH);
    inj_v = 1'b1;
    inj_d = W'($urandom);
    step();
    inj_v = 1'b0;
    check("full_perr", o_perror, 1);
    check("full_cnt", o_cnt, DEPTH);
    o_r = 1'b1;
    repeat (DEPTH + 2) step();
    check("full_drain_v", o_v, 0);
    pulse_reset();

    // Reset with two results queued and two in flight.
    o_r = 1'b0;
    i_issue_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      iss_d = W'($urandom);
      step();
    end
    i_issue_v = 1'b0;
    step();
    check("mid_pre_cnt", o_cnt, 4);
    check("mid_pre_v", o_v, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_v", o_v, 0);
    check("mid_rst_cnt", o_cnt, 0);
    check("mid_rst_issue_r", o_issue_r, 1);
    step();
    step();
    reset = 1'b1;
    o_r = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      if (o_v) stale++;
      step();
    end
    check("mid_no_stale", stale, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
